// File: rtl/dbd_timing_pkg.sv
// Shared timing constants, count widths and FSM state type for the dynamic-backlight
// position path.
package dbd_timing_pkg;

  localparam int unsigned H_ACTIVE = 1920;  // active pixels per line
  localparam int unsigned BLOCK_W  = 80;    // pixels per horizontal backlight block
  localparam int unsigned N_BLOCKS = 24;    // blocks per line
  localparam int unsigned V_ACTIVE = 1080;  // active lines per frame

  localparam int unsigned HCNT_W = 12;  // pixel index width
  localparam int unsigned HBLK_W = 5;   // block index width
  localparam int unsigned DUTY_W = 7;   // position-within-block width
  localparam int unsigned VCNT_W = 12;  // line index width
  localparam int unsigned LEN_W  = 13;  // raw line length, wide enough to see overlong lines

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StOverrun,
    StWaitVsClr
  } state_e;

endpackage

// File: rtl/edge_det.sv
// Rise/fall detector against a registered copy of the input.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   d_i           : input level
//   rise_o/fall_o : edge of d_i relative to the previous sampled value
// ResetVal sets the assumed previous level after reset; 1 suppresses a false rise
// for an input that is already high when reset is released.
module edge_det #(
  parameter logic ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q <= ResetVal;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;
  assign fall_o = ~d_i & d_q;

endmodule

// File: rtl/h_block_counter.sv
// Active-area position generator for the per-block backlight duty decoder.
//   iODCK, iRST_N        : pixel clock, asynchronous active-low reset
//   iDE, iVS             : panel data enable and vertical sync
//   oDE                  : line-valid, aligned with all count outputs
//   oH_Count/oH_Block/oH_Block_Duty_Count : pixel, block and in-block position
//   oBlock_Start/oLine_Start/oLine_End    : one-cycle markers
//   oV_Count, oFrame_Start                : line index and frame marker
//   oLen_Err             : line length differed from H_ACTIVE (with oLine_End)
// All outputs are registered.
module h_block_counter
  import dbd_timing_pkg::*;
(
  input  logic              iODCK,
  input  logic              iRST_N,
  input  logic              iDE,
  input  logic              iVS,
  output logic              oDE,
  output logic [HCNT_W-1:0] oH_Count,
  output logic [HBLK_W-1:0] oH_Block,
  output logic [DUTY_W-1:0] oH_Block_Duty_Count,
  output logic              oBlock_Start,
  output logic              oLine_Start,
  output logic              oLine_End,
  output logic [VCNT_W-1:0] oV_Count,
  output logic              oFrame_Start,
  output logic              oLen_Err
);

  localparam logic [HCNT_W-1:0] HMax    = HCNT_W'(H_ACTIVE - 1);
  localparam logic [DUTY_W-1:0] DutyMax = DUTY_W'(BLOCK_W - 1);
  localparam logic [VCNT_W-1:0] VMax    = VCNT_W'(V_ACTIVE - 1);
  localparam logic [LEN_W-1:0]  LenNom  = LEN_W'(H_ACTIVE);

  if (H_ACTIVE != BLOCK_W * N_BLOCKS) begin : gen_geom_check
    $error("H_ACTIVE must equal BLOCK_W * N_BLOCKS");
  end

  state_e           state_q;
  logic [LEN_W-1:0] len_q;
  logic             first_q;  // first clock after reset release
  logic             de_rise, de_fall, vs_rise, vs_fall;

  // Previous level assumed high: DE or VS already asserted at reset release is not an edge.
  edge_det #(.ResetVal(1'b1)) u_de_edge (
    .clk_i  (iODCK),
    .rst_ni (iRST_N),
    .d_i    (iDE),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  edge_det #(.ResetVal(1'b1)) u_vs_edge (
    .clk_i  (iODCK),
    .rst_ni (iRST_N),
    .d_i    (iVS),
    .rise_o (vs_rise),
    .fall_o (vs_fall)
  );

  always_ff @(posedge iODCK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q             <= StIdle;
      len_q               <= '0;
      first_q             <= 1'b1;
      oDE                 <= 1'b0;
      oH_Count            <= '0;
      oH_Block            <= '0;
      oH_Block_Duty_Count <= '0;
      oBlock_Start        <= 1'b0;
      oLine_Start         <= 1'b0;
      oLine_End           <= 1'b0;
      oV_Count            <= '0;
      oFrame_Start        <= 1'b0;
      oLen_Err            <= 1'b0;
    end else begin
      first_q      <= 1'b0;
      oBlock_Start <= 1'b0;
      oLine_Start  <= 1'b0;
      oLine_End    <= 1'b0;
      oLen_Err     <= 1'b0;
      oFrame_Start <= vs_rise;
      // Frame restart is independent of the horizontal state; a line in flight keeps counting.
      if (vs_rise) begin
        oV_Count <= '0;
      end

      unique case (state_q)
        StIdle: begin
          if (first_q && iVS) begin
            state_q <= StWaitVsClr;
          end else if (de_rise) begin
            state_q             <= StActive;
            oDE                 <= 1'b1;
            oH_Count            <= '0;
            oH_Block            <= '0;
            oH_Block_Duty_Count <= '0;
            oLine_Start         <= 1'b1;
            oBlock_Start        <= 1'b1;
            len_q               <= LEN_W'(1);
          end
        end

        StWaitVsClr: begin
          if (vs_fall) begin
            state_q <= StIdle;
          end
        end

        StActive, StOverrun: begin
          if (de_fall) begin
            state_q             <= StIdle;
            oDE                 <= 1'b0;
            oH_Count            <= '0;
            oH_Block            <= '0;
            oH_Block_Duty_Count <= '0;
            oLine_End           <= 1'b1;
            oLen_Err            <= (len_q != LenNom);
            if (!vs_rise && (oV_Count != VMax)) begin
              oV_Count <= oV_Count + 1'b1;
            end
          end else begin
            len_q <= len_q + 1'b1;
            if ((state_q == StOverrun) || (oH_Count == HMax)) begin
              // Counts already sit at their last legal values; hold them.
              state_q <= StOverrun;
            end else begin
              oH_Count <= oH_Count + 1'b1;
              if (oH_Block_Duty_Count == DutyMax) begin
                oH_Block_Duty_Count <= '0;
                oH_Block            <= oH_Block + 1'b1;
                oBlock_Start        <= 1'b1;
              end else begin
                oH_Block_Duty_Count <= oH_Block_Duty_Count + 1'b1;
              end
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_h_block_counter.sv
module tb_h_block_counter;

  logic        clk = 1'b0;
  logic        rst_n, de, vs;
  logic        o_de, o_bs, o_ls, o_le, o_fs, o_lerr;
  logic [11:0] o_h, o_v;
  logic [4:0]  o_blk;
  logic [6:0]  o_duty;

  h_block_counter dut (
    .iODCK               (clk),
    .iRST_N              (rst_n),
    .iDE                 (de),
    .iVS                 (vs),
    .oDE                 (o_de),
    .oH_Count            (o_h),
    .oH_Block            (o_blk),
    .oH_Block_Duty_Count (o_duty),
    .oBlock_Start        (o_bs),
    .oLine_Start         (o_ls),
    .oLine_End           (o_le),
    .oV_Count            (o_v),
    .oFrame_Start        (o_fs),
    .oLen_Err            (o_lerr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: a line is a run of sampled DE-high cycles; pix counts them.
  bit m_first, m_de_prev, m_vs_prev, m_in_line, m_wait;
  int m_pix, m_v;
  bit e_de, e_bs, e_ls, e_le, e_fs, e_lerr;
  int e_h, e_blk, e_duty, e_v;

  // Observed-pulse tallies used by the literal checks.
  int n_bs, n_le, n_lerr, n_both, n_fs, n_hold, max_v;
  int last_h, last_blk, last_duty;
  int s_bs, s_le, s_lerr, s_both, s_fs, s_hold;

  task automatic model_reset();
    m_first = 1; m_de_prev = 1; m_vs_prev = 1; m_in_line = 0; m_wait = 0;
    m_pix = 0; m_v = 0;
    e_de = 0; e_bs = 0; e_ls = 0; e_le = 0; e_fs = 0; e_lerr = 0;
    e_h = 0; e_blk = 0; e_duty = 0; e_v = 0;
  endtask

  task automatic model_edge();
    bit vs_rise;
    int hh;
    if (!rst_n) begin
      model_reset();
      return;
    end
    vs_rise = vs && !m_vs_prev;
    e_le = 0; e_lerr = 0;
    e_fs = vs_rise;
    if (vs_rise) m_v = 0;
    if (m_wait) begin
      if (!vs) m_wait = 0;
    end else if (!m_in_line) begin
      if (m_first && vs) m_wait = 1;
      else if (de && !m_de_prev) begin
        m_in_line = 1;
        m_pix = 1;
      end
    end else if (!de) begin
      m_in_line = 0;
      e_le = 1;
      e_lerr = (m_pix != 1920);
      if (!vs_rise && m_v < 1079) m_v = m_v + 1;
      m_pix = 0;
    end else begin
      m_pix = m_pix + 1;
    end
    m_de_prev = de;
    m_vs_prev = vs;
    m_first = 0;
    e_de = m_in_line;
    e_v = m_v;
    if (m_in_line) begin
      hh = (m_pix - 1 > 1919) ? 1919 : m_pix - 1;
      e_h = hh; e_blk = hh / 80; e_duty = hh % 80;
      e_bs = (m_pix <= 1920) && ((m_pix - 1) % 80 == 0);
      e_ls = (m_pix == 1);
    end else begin
      e_h = 0; e_blk = 0; e_duty = 0; e_bs = 0; e_ls = 0;
    end
  endtask

  function automatic logic [41:0] dut_vec();
    return {o_de, o_h, o_blk, o_duty, o_bs, o_ls, o_le, o_v, o_fs, o_lerr};
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  task automatic compare();
    logic [41:0] exp;
    exp = {e_de, 12'(e_h), 5'(e_blk), 7'(e_duty), e_bs, e_ls, e_le, 12'(e_v), e_fs, e_lerr};
    checks++;
    if (dut_vec() !== exp) begin
      errors++;
      $display("FAIL cycle_compare at %0t: got %h expected %h", $time, dut_vec(), exp);
    end
    n_bs += int'(o_bs);
    n_le += int'(o_le);
    n_lerr += int'(o_lerr);
    n_both += int'(o_le && o_lerr);
    n_fs += int'(o_fs);
    if (o_de && o_h == 12'd1919) n_hold++;
    if (int'(o_v) > max_v) max_v = int'(o_v);
    if (o_de) begin
      last_h = int'(o_h); last_blk = int'(o_blk); last_duty = int'(o_duty);
    end
  endtask

  // Inputs change only after the falling edge; the model follows each rising edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic snap();
    s_bs = n_bs; s_le = n_le; s_lerr = n_lerr; s_both = n_both; s_fs = n_fs; s_hold = n_hold;
  endtask

  task automatic run_line(int len, int gap);
    de = 1'b1;
    repeat (len) step();
    de = 1'b0;
    repeat (gap) step();
  endtask

  initial begin
    n_bs = 0; n_le = 0; n_lerr = 0; n_both = 0; n_fs = 0; n_hold = 0; max_v = 0;
    last_h = 0; last_blk = 0; last_duty = 0;
    model_reset();
    rst_n = 1'b0; de = 1'b0; vs = 1'b0;
    repeat (2) step();
    chk("reset_outputs", longint'(dut_vec()), 0);
    rst_n = 1'b1;
    repeat (5) step();

    // Nominal 1920-pixel line.
    snap();
    run_line(1920, 5);
    chk("nominal_block_starts", n_bs - s_bs, 24);
    chk("nominal_line_ends", n_le - s_le, 1);
    chk("nominal_len_err", n_lerr - s_lerr, 0);
    chk("nominal_last_h", last_h, 1919);
    chk("nominal_last_block", last_blk, 23);
    chk("nominal_last_duty", last_duty, 79);

    // Short line.
    snap();
    run_line(1000, 5);
    chk("short_last_h", last_h, 999);
    chk("short_last_block", last_blk, 12);
    chk("short_last_duty", last_duty, 39);
    chk("short_len_err_with_end", n_both - s_both, 1);

    // Long line: 1919 reached once, then held for 80 further cycles.
    snap();
    run_line(2000, 5);
    chk("long_hold_cycles", n_hold - s_hold, 81);
    chk("long_last_block", last_blk, 23);
    chk("long_last_duty", last_duty, 79);
    chk("long_len_err_with_end", n_both - s_both, 1);
    chk("v_after_three_lines", o_v, 3);

    // VS rising in the middle of a line.
    snap();
    de = 1'b1;
    repeat (501) step();
    chk("vsmid_h_before", o_h, 500);
    vs = 1'b1;
    step();
    chk("vsmid_v_cleared", o_v, 0);
    chk("vsmid_h_continues", o_h, 501);
    chk("vsmid_frame_start", o_fs, 1);
    vs = 1'b0;
    step();
    chk("vsmid_h_next", o_h, 502);
    repeat (1920 - 503) step();
    de = 1'b0;
    repeat (5) step();
    chk("vsmid_len_err", n_lerr - s_lerr, 0);
    chk("vsmid_v_after", o_v, 1);

    // Frame: oV_Count advances on every line end regardless of length, so short
    // back-to-back lines with a 1-cycle gap exercise the full range quickly.
    snap();
    vs = 1'b1;
    repeat (2) step();
    vs = 1'b0;
    step();
    chk("frame_v_cleared", o_v, 0);
    max_v = 0;
    for (int i = 0; i < 1082; i++) run_line(20, 1);
    chk("frame_start_count", n_fs - s_fs, 1);
    chk("frame_max_v", max_v, 1079);
    chk("frame_v_saturated", o_v, 1079);
    repeat (4) step();

    // Reset in the middle of a line, released while DE is still high.
    de = 1'b1;
    repeat (301) step();
    chk("rstmid_h_before", o_h, 300);
    rst_n = 1'b0;
    #1;
    chk("rstmid_async_zero", longint'(dut_vec()), 0);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("rstmid_de_ignored", o_de, 0);
    chk("rstmid_h_idle", o_h, 0);
    snap();
    de = 1'b0;
    step();
    chk("rstmid_no_line_end", n_le - s_le, 0);
    de = 1'b1;
    step();
    chk("rstmid_restart_line_start", o_ls, 1);
    chk("rstmid_restart_block_start", o_bs, 1);
    repeat (99) step();
    chk("rstmid_restart_h", o_h, 99);
    de = 1'b0;
    repeat (3) step();

    // VS already high at reset release: lines are ignored until VS drops.
    rst_n = 1'b0;
    vs = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    snap();
    run_line(50, 3);
    chk("vswait_no_line_end", n_le - s_le, 0);
    chk("vswait_no_frame_start", n_fs - s_fs, 0);
    vs = 1'b0;
    step();
    run_line(10, 1);
    chk("vswait_line_counted", n_le - s_le, 1);
    chk("vswait_v", o_v, 1);
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
